// File: rtl/round_sequencer.sv
// Round controller: accept a block, iterate NUM_ROUNDS, present the result, wipe.
// out_valid first rises NUM_ROUNDS+1 cycles after accept; it holds until out_ready; abort cancels via WIPE.
module round_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int ROUND_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               reg_cl,
  output logic               reg_w,
  output logic               sel_load,
  output logic [ROUND_W-1:0] round_idx,
  output logic               last_round,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2,
    S_WIPE  = 2'd3
  } state_t;

  localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(NUM_ROUNDS - 1);

  state_t             state_q, state_d;
  logic [ROUND_W-1:0] cnt_q, cnt_d;

  logic in_ready_raw, reg_w_raw, sel_load_raw, wipe_cl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    in_ready_raw = 1'b0;
    reg_w_raw    = 1'b0;
    sel_load_raw = 1'b0;
    wipe_cl      = 1'b0;
    out_valid    = 1'b0;
    round_idx    = '0;
    last_round   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready_raw = ~abort;
        sel_load_raw = 1'b1;
        reg_w_raw    = in_valid & ~abort;
        if (in_valid && !abort) begin
          state_d = S_ROUND;
          cnt_d   = '0;
        end
      end
      S_ROUND: begin
        // abort suppresses the write so the partial state is never updated
        reg_w_raw  = ~abort;
        round_idx  = cnt_q;
        last_round = (cnt_q == LAST_IDX);
        if (abort) begin
          state_d = S_WIPE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_IDX) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ROUND_W'(1);
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (abort || out_ready) state_d = S_WIPE;
      end
      S_WIPE: begin
        wipe_cl = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // While in reset the register is cleared every edge and nothing else is asserted.
  assign reg_cl   = ~rst_n | wipe_cl;
  assign in_ready = rst_n & in_ready_raw;
  assign reg_w    = rst_n & reg_w_raw;
  assign sel_load = rst_n & sel_load_raw;
  assign busy     = (state_q != S_IDLE);

endmodule
